// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_dint4 lane: sequencer state encoding
// and the DINT4 operand/accumulator widths.
package mac_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ACC_WIDTH  = 17;

  localparam logic [3:0] DINT4_ZERO = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mac_dint4_seq_if.sv
// Operand stream and result port of the mac_dint4 sequencer. The master is the
// tile side (drives operands, consumes results); the slave is the sequencer.
interface mac_dint4_seq_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 17
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_weight;
  logic [DATA_WIDTH-1:0]       in_act;

  logic                        res_valid;
  logic                        res_ready;
  logic signed [ACC_WIDTH-1:0] res_data;

  modport master (
    output in_valid, in_weight, in_act, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_weight, in_act, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_dint4_seq.sv
// Dot-product sequencer for one mac_dint4 lane: clears the MAC, streams K
// operand pairs into it, waits out the MAC pipeline and returns the sum.
module mac_dint4_seq
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 17,
  parameter int LEN_WIDTH  = 10,
  parameter int MAC_LAT    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        abort,
  output logic                        busy,
  mac_dint4_seq_if.slave              io,
  output logic                        mac_clear,
  output logic                        mac_en,
  output logic [DATA_WIDTH-1:0]       mac_weight,
  output logic [DATA_WIDTH-1:0]       mac_act,
  input  logic signed [ACC_WIDTH-1:0] mac_out
);

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
  localparam logic [DATA_WIDTH-1:0] OP_ZERO = DATA_WIDTH'(DINT4_ZERO);

  seq_state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [DRAIN_W-1:0]          drain_q, drain_d;
  logic                        aborting_q, aborting_d;
  logic signed [ACC_WIDTH-1:0] res_data_q, res_data_d;
  logic                        in_ready;
  logic                        handshake;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps the block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    aborting_d = aborting_q;
    res_data_d = res_data_q;
    in_ready   = 1'b0;
    handshake  = 1'b0;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    mac_weight = OP_ZERO;
    mac_act    = OP_ZERO;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = len;
          aborting_d = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear = 1'b1;
        drain_d   = '0;
        if (aborting_q)      state_d = IDLE;
        else if (cnt_q == '0) state_d = DRAIN;
        else                 state_d = RUN;
      end
      RUN: begin
        in_ready  = !abort;
        mac_en    = 1'b1;
        handshake = io.in_valid && in_ready;
        // Bubbles feed code 0 so the MAC adds nothing for an idle cycle.
        if (handshake) begin
          mac_weight = io.in_weight;
          mac_act    = io.in_act;
          cnt_d      = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        mac_en = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          res_data_d = mac_out;
          state_d    = DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE: begin
        if (io.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: one clear pulse, then back to IDLE.
    if (abort && (state_q != IDLE)) begin
      state_d    = CLEAR;
      aborting_d = 1'b1;
      res_data_d = res_data_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drain_q    <= '0;
      aborting_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      aborting_q <= aborting_d;
      res_data_q <= res_data_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign io.in_ready  = in_ready;
  assign io.res_valid = (state_q == DONE);
  assign io.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dint4_seq.sv
// Self-checking bench for mac_dint4_seq: a behavioural MAC stands in for the
// lane's MAC, and each job's result is predicted from the offered pairs.
module tb_mac_dint4_seq;
  import mac_pkg::*;

  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [9:0]        len;
  logic              abort;
  logic              busy;
  logic              mac_clear;
  logic              mac_en;
  logic [3:0]        mac_weight;
  logic [3:0]        mac_act;
  logic signed [16:0] mac_out;

  mac_dint4_seq_if #(.DATA_WIDTH(4), .ACC_WIDTH(17)) io ();

  mac_dint4_seq #(
    .DATA_WIDTH(4), .ACC_WIDTH(17), .LEN_WIDTH(10), .MAC_LAT(LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .io        (io.slave),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .mac_weight(mac_weight),
    .mac_act   (mac_act),
    .mac_out   (mac_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DINT4: sign-magnitude code, value = +/- 2 * magnitude.
  function automatic int dint4(input logic [3:0] c);
    int m;
    m = 2 * int'(c[2:0]);
    return c[3] ? -m : m;
  endfunction

  // Behavioural MAC: operand register then accumulator, clear is synchronous.
  logic [3:0] mw_q, ma_q;
  logic signed [16:0] acc_q;
  always @(posedge clk) begin
    if (mac_clear) begin
      mw_q  <= '0;
      ma_q  <= '0;
      acc_q <= '0;
    end else if (mac_en) begin
      mw_q  <= mac_weight;
      ma_q  <= mac_act;
      acc_q <= acc_q + 17'(dint4(mw_q) * dint4(ma_q));
    end
  end
  assign mac_out = acc_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  logic [3:0] q_w[$];
  logic [3:0] q_a[$];
  bit         q_v[$];
  bit         rand_valid = 0;
  int         first_hs_edge, last_hs_edge;
  logic signed [16:0] last_res;

  // Runs one job from IDLE. Entry and exit: 1 time unit after a rising edge.
  task automatic run_job(input int k, input int rr_hold, input bit poke);
    int hs, rdy, clr, start_edge, res_edge, budget, want_edge;
    logic signed [16:0] exp_acc;
    bit got, v;
    hs = 0; rdy = 0; clr = 0; res_edge = 0; got = 0;
    exp_acc = '0;
    budget = 4 * k + 40;
    start = 1'b1;
    len = 10'(k);
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (q_w.size() > 0) begin
        v = 1'b1;
        if (io.in_ready && q_v.size() > 0) v = q_v.pop_front();
        else if (io.in_ready && rand_valid) v = ($urandom_range(3) != 0);
      end else begin
        v = 1'b0;
      end
      io.in_valid  = v;
      io.in_weight = v ? q_w[0] : 4'($urandom);
      io.in_act    = v ? q_a[0] : 4'($urandom);
      @(negedge clk);
      if (mac_clear) clr++;
      if (io.in_ready) rdy++;
      if (io.in_ready && io.in_valid) begin
        check("pass_through", {23'd0, mac_en, mac_weight, mac_act}, {23'd0, 1'b1, q_w[0], q_a[0]});
        exp_acc = exp_acc + 17'(dint4(q_w[0]) * dint4(q_a[0]));
        void'(q_w.pop_front());
        void'(q_a.pop_front());
        hs++;
        if (hs == 1) first_hs_edge = cyc + 1;
        last_hs_edge = cyc + 1;
      end else if (io.in_ready) begin
        check("bubble_zero", {23'd0, mac_en, mac_weight, mac_act}, {23'd0, 1'b1, 8'h00});
      end
      if (io.res_valid) begin
        got = 1'b1;
        res_edge = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    io.in_valid = 1'b0;
    if (!got) begin
      check("res_timeout", 0, 1);
      @(posedge clk); #1;
      return;
    end
    want_edge = (k == 0) ? start_edge + 1 + LAT : last_hs_edge + LAT;
    check("res_latency", res_edge, want_edge);
    check("handshakes", hs, k);
    check("clear_pulses", clr, 1);
    if (k == 0) check("no_ready_k0", rdy, 0);
    check("res_data", io.res_data, exp_acc);
    last_res = io.res_data;
    for (int i = 0; i < rr_hold; i++) begin
      @(posedge clk); #1;
      start = poke;
      len = 10'd5;
      @(negedge clk);
      check("res_hold", {14'd0, io.res_valid, io.res_data}, {14'd0, 1'b1, exp_acc});
    end
    @(posedge clk); #1;
    start = 1'b0;
    io.res_ready = 1'b1;
    @(posedge clk); #1;
    io.res_ready = 1'b0;
    @(negedge clk);
    check("idle_after_ack", {busy, io.res_valid}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    io.in_valid = 1'b0;
    io.in_weight = '0;
    io.in_act = '0;
    io.res_ready = 1'b0;
    #2;
    check("reset_outputs",
          {7'd0, busy, io.in_ready, mac_clear, mac_en, mac_weight, mac_act, io.res_valid, io.res_data},
          32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Three back-to-back pairs, 4 * 6 each; result held under backpressure.
    q_w = {4'b0011, 4'b0011, 4'b0011};
    q_a = {4'b0010, 4'b0010, 4'b0010};
    run_job(3, 5, 1'b1);
    check("job_72", last_res, 72);
    check("consecutive_hs", last_hs_edge - first_hs_edge, 2);

    // -24 then +24 with two bubbles in between.
    q_w = {4'b0011, 4'b0011};
    q_a = {4'b1010, 4'b0010};
    q_v = {1'b1, 1'b0, 1'b0, 1'b1};
    run_job(2, 0, 1'b0);
    check("job_cancel", last_res, 0);

    // Empty job.
    run_job(0, 1, 1'b0);
    check("job_k0", last_res, 0);

    // Abort after the first of four handshakes.
    q_w = {4'b0011, 4'b0011, 4'b0011, 4'b0011};
    q_a = {4'b0010, 4'b0010, 4'b0010, 4'b0010};
    start = 1'b1; len = 10'd4;
    io.in_valid = 1'b1; io.in_weight = 4'b0011; io.in_act = 4'b0010;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_first_hs", io.in_ready, 1'b1);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    check("abort_ready_low", io.in_ready, 1'b0);
    @(posedge clk); #1 abort = 1'b0; io.in_valid = 1'b0;
    @(negedge clk);
    check("abort_clear", {busy, mac_clear, io.in_ready, io.res_valid}, 4'b1100);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_idle", {busy, mac_clear}, 2'b00);
    begin
      bit seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (io.res_valid) seen = 1;
      end
      check("abort_no_result", seen, 0);
    end
    @(posedge clk); #1;
    q_w.delete(); q_a.delete();
    q_w = {4'b0001};
    q_a = {4'b0001};
    run_job(1, 0, 1'b0);
    check("job_after_abort", last_res, 4);

    // Reset pulse in the first DRAIN cycle of a one-pair job.
    start = 1'b1; len = 10'd1;
    io.in_valid = 1'b1; io.in_weight = 4'b0111; io.in_act = 4'b0111;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_mid_drain",
          {7'd0, busy, io.in_ready, mac_clear, mac_en, mac_weight, mac_act, io.res_valid, io.res_data},
          32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    q_w = {4'b0101, 4'b1110};
    q_a = {4'b0011, 4'b0010};
    run_job(2, 0, 1'b0);

    // Random jobs with random valid gaps and result backpressure.
    rand_valid = 1;
    for (int j = 0; j < 8; j++) begin
      int k;
      k = $urandom_range(12);
      q_w.delete(); q_a.delete();
      for (int i = 0; i < k; i++) begin
        q_w.push_back(4'($urandom));
        q_a.push_back(4'($urandom));
      end
      run_job(k, $urandom_range(3), 1'($urandom_range(1)));
    end

    // Longest job: 1023 maximal products, accumulator wraps.
    rand_valid = 0;
    q_w.delete(); q_a.delete();
    for (int i = 0; i < 1023; i++) begin
      q_w.push_back(4'b0111);
      q_a.push_back(4'b0111);
    end
    run_job(1023, 0, 1'b0);
    check("job_max_wrap", last_res, -61636);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dint4_seq.md
Name: mac_dint4_seq

Overview:
- Dot-product sequencer for one mac_dint4 lane: accepts a job (length K), streams K weight/act pairs from a valid/ready source into the MAC, drains the MAC pipeline, and returns the accumulated result over a valid/ready result port.
- Owns the MAC's synchronous clear and enable.
- Sits between the tile operand buffers and one MAC instance.

Parameters:
- DATA_WIDTH, 4, operand width; must match the MAC.
- ACC_WIDTH, 17, accumulator/result width; must match the MAC.
- LEN_WIDTH, 10, width of the job length field; max K = 2^LEN_WIDTH-1.
- MAC_LAT, 2, cycles from an operand pair on mac_* to its inclusion in mac_out (input register + accumulator register).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_WIDTH  element count K; captured with start
- abort  in  1  cancel current job
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_weight  in  DATA_WIDTH  weight code (sign-magnitude DINT4)
- in_act  in  DATA_WIDTH  activation code
- mac_clear  out  1  to MAC reset (sync, active-high)
- mac_en  out  1  to MAC en
- mac_weight  out  DATA_WIDTH  to MAC weight
- mac_act  out  DATA_WIDTH  to MAC act
- mac_out  in  ACC_WIDTH signed  from MAC out
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  ACC_WIDTH signed  captured dot product

Behaviour:
- Reset (reset_n low, async):
  - State is IDLE.
  - All outputs are 0: busy, in_ready, mac_clear, mac_en, mac_weight, mac_act, res_valid, res_data.
  - Element and drain counters are 0.
- IDLE:
  - On start=1, capture len into a remaining-count register and go to CLEAR.
  - Ignore start in every other state; no queueing.
- CLEAR (1 cycle):
  - mac_clear=1, mac_en=0, in_ready=0.
  - Next state is RUN if K>0, else DRAIN.
- RUN:
  - in_ready=1 and mac_en=1 every cycle.
  - On a handshake (in_valid & in_ready), drive mac_weight/mac_act with the pair combinationally and decrement the count.
  - On a bubble (no handshake), drive mac_weight=mac_act=0. Code 0 gives product 0, so the MAC never re-accumulates held operands.
  - The handshake that brings the count to 0 moves the sequencer to DRAIN. in_ready is 0 from the next cycle.
- DRAIN:
  - Lasts MAC_LAT cycles; mac_en=1, zero operands, in_ready=0.
  - On the last DRAIN cycle, register res_data <= mac_out and res_valid <= 1, then go to DONE.
- DONE:
  - res_valid=1; res_data is held stable until handshake.
  - On res_valid & res_ready, res_valid drops next cycle and the sequencer returns to IDLE.
  - res_ready low holds DONE indefinitely.
- abort=1 in CLEAR, RUN, DRAIN or DONE:
  - Next cycle: state CLEAR-then-IDLE, i.e. one mac_clear pulse followed by IDLE.
  - in_ready=0 and res_valid=0 immediately after the abort edge.
  - No result is delivered. A pending pair in the abort cycle is not accepted (in_ready forced 0 while abort=1).
  - abort has priority over start, handshakes and the DRAIN exit.
- Latency:
  - K=0: start to res_valid = 1+MAC_LAT cycles.
  - Otherwise: last input handshake to res_valid = MAC_LAT cycles.
- Arithmetic:
  - The sequencer does no arithmetic on data; it passes codes through unmodified.
  - Accumulator overflow wraps inside the MAC; it is not detected here.
  - The count is unsigned LEN_WIDTH.
- reset_n asserted mid-job:
  - Everything returns to reset values asynchronously; no partial result is kept.
  - The MAC is not cleared by this block during reset. The first CLEAR after reset guarantees a clean accumulator.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum seq_state_t {IDLE, CLEAR, RUN, DRAIN, DONE};
  - constants DINT4_ZERO = 4'b0000, DATA_WIDTH, ACC_WIDTH.
- The MAC instance lives at the lane top level, not inside this block.
- No sub-module is needed. Counters and FSM stay in one module.

Test Plan:
- len=3, pairs (act 4'b0010, wt 4'b0011) x3, in_valid always 1 -> three consecutive handshakes, res_data=72 (3 x 4 x 6), res_valid exactly MAC_LAT cycles after the 3rd handshake.
- len=2, pairs (4'b1010, 4'b0011) then (4'b0010, 4'b0011), in_valid=1,0,0,1 -> bubbles drive zero operands with mac_en=1, res_data=0 (-24+24).
- len=0 with start -> in_ready never 1, one mac_clear pulse, res_data=0 after 1+MAC_LAT cycles.
- Result backpressure: res_ready low 5 cycles after res_valid, start pulsed meanwhile -> res_data stable, start ignored, IDLE one cycle after res_ready=1.
- abort during RUN after 1 of 4 handshakes -> in_ready=0 that cycle, one mac_clear pulse, IDLE, res_valid never asserted. A following len=1 job (4'b0001, 4'b0001) gives res_data=4.
- reset_n low for 1 cycle mid-DRAIN -> all outputs 0 immediately, busy=0, a subsequent job yields the correct result.
